irq_controller: RTL
===================

# irq_controller

Interrupt source for the pipelined core's `interrupt` input. It edge-detects external request lines and an internal periodic timer, and holds them as pending bits. It applies a mask and fixed priority, then presents one interrupt at a time to the core with a cause ID. The handshake is request, then `ack` when the core enters the handler, then `eoi` on handler return.

## Interface

Parameters:
- `N_SRC`, default 4: number of external request lines (1..7); timer is source index `N_SRC`.
- `TIMER_W`, default 16: width of timer counter and compare register.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `irq_src`  in  N_SRC  external request lines, synchronous to `clk`; rising edge = one event.
- `mask_we`  in  1  write strobe for mask register.
- `mask_wdata`  in  N_SRC+1  new mask; bit=1 enables source (bit `N_SRC` = timer).
- `timer_we`  in  1  write strobe for timer compare.
- `timer_wdata`  in  TIMER_W  new compare value; 0 disables timer.
- `ack`  in  1  one-cycle pulse: core has taken the interrupt.
- `eoi`  in  1  one-cycle pulse: handler returned (mret).
- `interrupt`  out  1  interrupt request to core, registered.
- `cause_id`  out  3  index of source being requested/serviced, registered.
- `pending`  out  N_SRC+1  raw pending bits (unmasked view), registered.

## Operation

- Edge detect: `src_q` register holds the previous `irq_src`. An event is `irq_src & ~src_q`, and it sets the matching pending bit at the same edge. A line held high produces one event only.
- Timer: `cnt` increments each cycle while compare≠0. When `cnt`==compare, the timer pending bit is set and `cnt` is set to 0, giving a period of compare+1 cycles. With compare=0, `cnt` is held at 0. `timer_we` loads compare and clears `cnt`.
- Mask write takes effect on the next edge. Masked sources still latch pending; unmasking later makes them eligible.
- Priority: lowest index wins; the timer has the lowest priority. Candidate = lowest set bit of `pending & mask`.
- FSM:
  - IDLE: `interrupt`=0. If any candidate exists, latch `cause_id`=candidate and go to REQ.
  - REQ: `interrupt`=1 and `cause_id` frozen. Later higher-priority arrivals and mask changes do not alter the request. On `ack`, clear `pending[cause_id]` and go to SERVICE.
  - SERVICE: `interrupt`=0 and `cause_id` held. There is no nesting. On `eoi`, go to IDLE.
- Ignored inputs: `ack` outside REQ; `eoi` outside SERVICE.
- Simultaneous event on `cause_id` and `ack` in the same cycle: pending stays set, so the new event is not lost.
- Simultaneous `eoi` and new events: go to IDLE; arbitration happens in the following cycle.

## Timing

- Reset values: `interrupt`=0, `cause_id`=0, `pending`=0, FSM=IDLE, `src_q`=0, `cnt`=0, compare=0, mask=all ones.
- Reset mid-operation (any state) returns all of the above immediately. Pending events are discarded.
- Latency: event sampled at edge k, so the pending bit is visible after edge k. `interrupt` rises after edge k+1, which is 2 cycles from input edge to request.
- After `ack` at edge a, `interrupt` is low after edge a. The earliest next request after `eoi` at edge e is after edge e+1.
- `cause_id` width: 3 bits; unused upper values never produced.
- Timer with compare=C: first pending set C+1 cycles after `timer_we`, then every C+1 cycles. A timer event while the timer pending bit is already set is merged (no counting).

## Test plan

- Reset, then pulse `irq_src[2]` for 2 cycles. Required: `interrupt`=1 two cycles after the rise, `cause_id`=2. `ack` drops `interrupt` and clears `pending[2]`. `eoi` returns to IDLE and no second request follows.
- Raise `irq_src[3]` and `irq_src[1]` in the same cycle. Required: `cause_id`=1 first. After ack/eoi, `cause_id`=3. `irq_src[0]` arriving during REQ does not change `cause_id`.
- Write compare=5 with mask=all ones. Required: timer pending at 6 cycles after the write, then every 6 cycles. Request `cause_id`=N_SRC=4. Compare=0 gives no further timer events.
- Set mask=0 and pulse `irq_src[0]`. Required: `pending[0]`=1 and `interrupt` stays 0. Writing mask bit0=1 gives `interrupt`=1 two cycles after the write, with `cause_id`=0.
- Pulse `irq_src[2]`, then drive an `irq_src[2]` rising edge on the same edge as `ack`. Required: `pending[2]` remains 1, and a new request with `cause_id`=2 follows `eoi`.
- Assert `rst` while in SERVICE with pending bits set. Required: all outputs are 0 at once. After release, stray `ack`/`eoi` pulses cause no request.

Source files
------------

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : Edge-detecting interrupt source for the pipelined core.
//                External request lines plus an internal periodic timer are
//                latched as pending bits, masked, prioritised (lowest index
//                wins, timer lowest) and presented one at a time with a
//                request / ack / eoi handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_controller #(
    parameter int N_SRC   = 4,
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               mask_we,
    input  logic [N_SRC:0]     mask_wdata,
    input  logic               timer_we,
    input  logic [TIMER_W-1:0] timer_wdata,
    input  logic               ack,
    input  logic               eoi,
    output logic               interrupt,
    output logic [2:0]         cause_id,
    output logic [N_SRC:0]     pending
);

    // Total number of pending bits: external lines plus the timer.
    localparam int NS = N_SRC + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_SRC-1:0]   r_src_q;
    logic [NS-1:0]      r_pend;
    logic [NS-1:0]      r_mask;
    logic [TIMER_W-1:0] r_cmp;
    logic [TIMER_W-1:0] r_cnt;
    logic               r_interrupt;
    logic [2:0]         r_cause;

    logic [N_SRC-1:0]   w_ext_evt;
    logic               w_tmr_hit;
    logic [NS-1:0]      w_evt;
    logic [NS-1:0]      w_clr;
    logic [NS-1:0]      w_elig;
    logic               w_any;
    logic [2:0]         w_cand;
    logic               w_take_ack;

    // Rising-edge detection on the external lines; a held-high line yields
    // a single event.
    assign w_ext_evt = irq_src & ~r_src_q;

    // Timer fires when the running count reaches the non-zero compare value.
    // A compare write on the same edge restarts the period instead.
    assign w_tmr_hit = (r_cmp != '0) && (r_cnt == r_cmp) && !timer_we;

    assign w_evt = {w_tmr_hit, w_ext_evt};

    // The serviced source's pending bit is dropped only when the core acks
    // the request; a fresh event on the same edge re-sets it below.
    assign w_take_ack = (r_state == ST_REQ) && ack;
    assign w_clr      = w_take_ack ? (NS'(1) << r_cause) : '0;

    assign w_elig = r_pend & r_mask;
    assign w_any  = |w_elig;

    // Fixed-priority encoder: lowest eligible index wins.
    always_comb begin
        w_cand = 3'd0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_cand = 3'(i);
            end
        end
    end

    // Previous-sample register for the external request lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_q <= '0;
        end else begin
            r_src_q <= irq_src;
        end
    end

    // Periodic timer: counts 0..compare, so the period is compare+1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp <= '0;
            r_cnt <= '0;
        end else if (timer_we) begin
            r_cmp <= timer_wdata;
            r_cnt <= '0;
        end else if (r_cmp == '0) begin
            r_cnt <= '0;
        end else if (r_cnt == r_cmp) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Mask register; reset enables every source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    // Pending bits latch regardless of mask; new events take precedence
    // over the ack clear so a coincident event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_evt;
        end
    end

    // Request handshake FSM with registered interrupt and cause outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_interrupt <= 1'b0;
            r_cause     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_REQ;
                        r_interrupt <= 1'b1;
                        r_cause     <= w_cand;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        r_state     <= ST_SERVICE;
                        r_interrupt <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_interrupt <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt = r_interrupt;
    assign cause_id  = r_cause;
    assign pending   = r_pend;

endmodule
`default_nettype wire
